// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : memory_responder
//  Description : Memory-side responder for the CPU single-port handshake
//                (readM/writeM, address, shared 16-bit data bus,
//                inputReady/ackOutput). Serves one access at a time after a
//                fixed LATENCY and acts as the system memory model.
//                Optional feature macro: MEM_RANGE_CHECK_EN (out-of-range
//                accesses return 16'hDEAD / drop writes and pulse err).
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_responder #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 inputReady,
    output logic                 ackOutput,
    output logic                 busy,
    output logic                 err
);

    localparam int                 c_DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0]         c_LAT_INIT = 4'(LATENCY - 1);
    localparam logic [WORD_SIZE-1:0] c_OOR_DATA = WORD_SIZE'(16'hDEAD);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [ADDR_BITS-1:0]   r_idx;
    logic                   r_oor;
    logic [WORD_SIZE-1:0]   r_wdata;
    logic [WORD_SIZE-1:0]   r_rdata;
    logic                   r_input_ready;
    logic                   r_ack_output;
    logic                   r_busy;
    logic                   r_err;
    logic [WORD_SIZE-1:0]   r_mem [0:c_DEPTH-1];

    logic                   w_addr_oor;
    logic                   w_mem_we;

`ifdef MEM_RANGE_CHECK_EN
    // Any set bit above the index field puts the access outside the array
    assign w_addr_oor = |address[WORD_SIZE-1:ADDR_BITS];
`else
    // Upper address bits are ignored: the index wraps modulo the depth
    logic w_unused_upper;
    assign w_unused_upper = ^address[WORD_SIZE-1:ADDR_BITS];
    assign w_addr_oor     = 1'b0;
`endif

    // The write commits on the same edge that enters WR_RESP; dropped if out of range
    assign w_mem_we = (r_state == ST_WR_WAIT) && writeM && (r_cnt == 4'd0) && !r_oor;

    // Read data is driven onto the shared bus only while a read response is up
    assign data       = r_input_ready ? r_rdata : {WORD_SIZE{1'bz}};
    assign inputReady = r_input_ready;
    assign ackOutput  = r_ack_output;
    assign busy       = r_busy;
    assign err        = r_err;

    // Storage array: not cleared by reset, written only on a committed write
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    // Handshake state machine with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_idx         <= '0;
            r_oor         <= 1'b0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_input_ready <= 1'b0;
            r_ack_output  <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (readM && writeM) begin
                        r_err <= 1'b1;
                    end else if (readM) begin
                        r_idx   <= address[ADDR_BITS-1:0];
                        r_oor   <= w_addr_oor;
                        r_cnt   <= c_LAT_INIT;
                        r_busy  <= 1'b1;
                        r_state <= ST_RD_WAIT;
                    end else if (writeM) begin
                        r_idx   <= address[ADDR_BITS-1:0];
                        r_oor   <= w_addr_oor;
                        r_wdata <= data;
                        r_cnt   <= c_LAT_INIT;
                        r_busy  <= 1'b1;
                        r_state <= ST_WR_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (!readM) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_rdata       <= r_oor ? c_OOR_DATA : r_mem[r_idx];
                        r_input_ready <= 1'b1;
                        r_err         <= r_oor;
                        r_state       <= ST_RD_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RD_RESP: begin
                    if (!readM) begin
                        r_input_ready <= 1'b0;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_WR_WAIT: begin
                    if (!writeM) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_ack_output <= 1'b1;
                        r_err        <= r_oor;
                        r_state      <= ST_WR_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_WR_RESP: begin
                    if (!writeM) begin
                        r_ack_output <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_input_ready <= 1'b0;
                    r_ack_output  <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
